// File: rtl/axi_lite_reg_master.sv
// Command queue feeding a one-outstanding AXI4-Lite master; completions return in push order.
// Latency: cmd accepted cycle N -> bus valid N+2; backpressure via cmd_ready (queue full) and rsp_ready.

// Synchronous FIFO with an extra wrap bit on each pointer so full and empty are distinguishable.
// Latency: push visible on pop side the next cycle; push_rdy low when full, pop_vld low when empty.
// Backpressure: a push while full is refused, so a simultaneous push and pop on a full FIFO cannot occur.
module axi_lite_reg_master_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             axi_aclk,
   input  logic             axi_reset,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push_rdy = !full;
   assign pop_vld  = !empty;
   assign pop_dat  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld && push_rdy) wr_ptr <= wr_ptr + 1'b1;
         if (pop_rdy && pop_vld)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (push_vld && push_rdy) mem[wr_ptr[AW-1:0]] <= push_dat;
   end
endmodule

// Register read/write master: pops one command, runs it on AXI4-Lite, holds the completion until taken.
// Latency: bus valid two cycles after an accepted command into an idle master; all bus outputs registered.
// Backpressure: cmd_ready drops when the queue is full; a completion stalls the master until rsp_ready.
module axi_lite_reg_master #(
   parameter int          ADDR_WIDTH     = 10,
   parameter int          DATA_WIDTH     = 32,
   parameter int          CMD_DEPTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                    axi_aclk,
   input  logic                    axi_reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    busy,
   output logic                    timeout_err,
   input  logic                    timeout_clr,
   output logic                    m_axi_lite_awvalid,
   output logic [ADDR_WIDTH-1:0]   m_axi_lite_awaddr,
   input  logic                    m_axi_lite_awready,
   output logic                    m_axi_lite_wvalid,
   output logic [DATA_WIDTH-1:0]   m_axi_lite_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_lite_wstrb,
   input  logic                    m_axi_lite_wready,
   input  logic                    m_axi_lite_bvalid,
   input  logic [1:0]              m_axi_lite_bresp,
   output logic                    m_axi_lite_bready,
   output logic                    m_axi_lite_arvalid,
   output logic [ADDR_WIDTH-1:0]   m_axi_lite_araddr,
   input  logic                    m_axi_lite_arready,
   input  logic                    m_axi_lite_rvalid,
   input  logic [DATA_WIDTH-1:0]   m_axi_lite_rdata,
   input  logic [1:0]              m_axi_lite_rresp,
   output logic                    m_axi_lite_rready
);
   localparam int          STRB_W  = DATA_WIDTH / 8;
   localparam int          TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0]     wstrb;
   } cmd_t;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

   state_t                state_q, state_d;
   cmd_t                  push_cmd, head;
   logic                  fifo_rdy, head_vld, fifo_pop, launch;
   logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic                  bready_q, bready_d, rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;
   logic [TO_W-1:0]       wd_cnt;
   logic                  waiting, wd_set, timeout_err_q;

   assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};

   axi_lite_reg_master_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .axi_aclk  (axi_aclk),
      .axi_reset (axi_reset),
      .push_vld  (cmd_valid),
      .push_rdy  (fifo_rdy),
      .push_dat  (push_cmd),
      .pop_vld   (head_vld),
      .pop_rdy   (fifo_pop),
      .pop_dat   (head)
   );

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      fifo_pop    = 1'b0;
      launch      = 1'b0;
      case (state_q)
         IDLE: launch = 1'b1;
         WR_REQ: begin
            // AW and W retire independently; leave only once both have handshaken
            if (awvalid_q && m_axi_lite_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axi_lite_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (m_axi_lite_bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = m_axi_lite_bresp;
               state_d     = RSP;
            end
         end
         RD_ADDR: begin
            if (m_axi_lite_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi_lite_rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = m_axi_lite_rdata;
               rsp_resp_d  = m_axi_lite_rresp;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
               launch      = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Shared by IDLE and the completion handshake so commands can issue back-to-back
      if (launch && head_vld) begin
         fifo_pop = 1'b1;
         addr_d   = head.addr;
         if (head.write) begin
            wdata_d   = head.wdata;
            wstrb_d   = head.wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
         end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
         end
      end
   end

   assign waiting = (state_q == WR_RESP) || (state_q == RD_DATA);
   assign wd_set  = (TIMEOUT_CYCLES != 0) && waiting && (wd_cnt == TO_W'(TO_LAST));

   // Counter sits at zero outside the wait states, so it restarts on every entry
   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         wd_cnt        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (!waiting)                                wd_cnt <= '0;
         else if (wd_cnt != TO_W'(TIMEOUT_CYCLES))    wd_cnt <= wd_cnt + 1'b1;
         if (wd_set)           timeout_err_q <= 1'b1;
         else if (timeout_clr) timeout_err_q <= 1'b0;
      end
   end

   assign cmd_ready          = fifo_rdy && !axi_reset;
   assign busy               = head_vld || (state_q != IDLE);
   assign timeout_err        = timeout_err_q;
   assign rsp_valid          = rsp_valid_q;
   assign rsp_write          = rsp_write_q;
   assign rsp_rdata          = rsp_rdata_q;
   assign rsp_resp           = rsp_resp_q;
   assign m_axi_lite_awvalid = awvalid_q;
   assign m_axi_lite_awaddr  = addr_q;
   assign m_axi_lite_wvalid  = wvalid_q;
   assign m_axi_lite_wdata   = wdata_q;
   assign m_axi_lite_wstrb   = wstrb_q;
   assign m_axi_lite_bready  = bready_q;
   assign m_axi_lite_arvalid = arvalid_q;
   assign m_axi_lite_araddr  = addr_q;
   assign m_axi_lite_rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Directed bench for axi_lite_reg_master: write/read paths, queue full, error responses, watchdog, reset.
module tb_axi_lite_reg_master;
   logic        axi_aclk = 1'b0;
   logic        axi_reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        busy, timeout_err, timeout_clr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [9:0]  awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0;
   int errors = 0;

   always #5 axi_aclk = ~axi_aclk;

   axi_lite_reg_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .axi_aclk(axi_aclk), .axi_reset(axi_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .busy(busy), .timeout_err(timeout_err), .timeout_clr(timeout_clr),
      .m_axi_lite_awvalid(awvalid), .m_axi_lite_awaddr(awaddr), .m_axi_lite_awready(awready),
      .m_axi_lite_wvalid(wvalid), .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
      .m_axi_lite_wready(wready),
      .m_axi_lite_bvalid(bvalid), .m_axi_lite_bresp(bresp), .m_axi_lite_bready(bready),
      .m_axi_lite_arvalid(arvalid), .m_axi_lite_araddr(araddr), .m_axi_lite_arready(arready),
      .m_axi_lite_rvalid(rvalid), .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
      .m_axi_lite_rready(rready)
   );

   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      chk("push_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   // Slave model for one transaction followed by the completion check
   task automatic do_txn(input string tag, input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] rd, input logic [1:0] resp);
      int n = 0;
      while (!(awvalid || arvalid) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_start"}, awvalid | arvalid, 1'b1);
      chk({tag, "_awvalid"}, awvalid, w);
      chk({tag, "_arvalid"}, arvalid, !w);
      if (w) begin
         chk({tag, "_awaddr"}, awaddr, a);
         chk({tag, "_wdata"}, wdata, d);
         chk({tag, "_wstrb"}, wstrb, s);
         awready = 1'b1; wready = 1'b1;
         tick();
         awready = 1'b0; wready = 1'b0;
         chk({tag, "_bready"}, bready, 1'b1);
         bvalid = 1'b1; bresp = resp;
         tick();
         bvalid = 1'b0;
      end else begin
         chk({tag, "_araddr"}, araddr, a);
         arready = 1'b1;
         tick();
         arready = 1'b0;
         chk({tag, "_rready"}, rready, 1'b1);
         rvalid = 1'b1; rdata = rd; rresp = resp;
         tick();
         rvalid = 1'b0;
      end
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, "_rsp_write"}, rsp_write, w);
      chk({tag, "_rsp_rdata"}, rsp_rdata, w ? 32'h0 : rd);
      chk({tag, "_rsp_resp"}, rsp_resp, resp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      axi_reset = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0; timeout_clr = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      #1 axi_reset = 1'b1;
      #11;
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout_err", timeout_err, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      tick();
      axi_reset = 1'b0;
      tick();

      // 1: simple write, AW and W accepted in the same cycle
      push_cmd(1'b1, 10'h000, 32'h0000_0001, 4'hF);
      chk("t1_n1_awvalid", awvalid, 1'b0);
      chk("t1_n1_busy", busy, 1'b1);
      tick();
      chk("t1_awvalid", awvalid, 1'b1);
      chk("t1_wvalid", wvalid, 1'b1);
      chk("t1_awaddr", awaddr, 10'h000);
      chk("t1_wdata", wdata, 32'h0000_0001);
      chk("t1_wstrb", wstrb, 4'hF);
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("t1_awvalid_drop", awvalid, 1'b0);
      chk("t1_wvalid_drop", wvalid, 1'b0);
      chk("t1_bready", bready, 1'b1);
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      chk("t1_bready_drop", bready, 1'b0);
      chk("t1_rsp_valid", rsp_valid, 1'b1);
      chk("t1_rsp_write", rsp_write, 1'b1);
      chk("t1_rsp_resp", rsp_resp, 2'b00);
      chk("t1_rsp_rdata", rsp_rdata, 32'h0);
      tick();
      chk("t1_rsp_hold", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t1_rsp_done", rsp_valid, 1'b0);
      chk("t1_busy_low", busy, 1'b0);

      // 2: awready delayed three cycles, wready immediate
      push_cmd(1'b1, 10'h008, 32'h1234_5678, 4'h3);
      tick();
      chk("t2_c1_awvalid", awvalid, 1'b1);
      chk("t2_c1_wvalid", wvalid, 1'b1);
      wready = 1'b1;
      tick();
      wready = 1'b0;
      chk("t2_c2_wvalid_drop", wvalid, 1'b0);
      chk("t2_c2_awvalid", awvalid, 1'b1);
      chk("t2_c2_bready", bready, 1'b0);
      tick();
      chk("t2_c3_awvalid", awvalid, 1'b1);
      chk("t2_c3_awaddr", awaddr, 10'h008);
      tick();
      chk("t2_c4_awvalid", awvalid, 1'b1);
      chk("t2_c4_awaddr", awaddr, 10'h008);
      chk("t2_c4_wvalid", wvalid, 1'b0);
      awready = 1'b1;
      tick();
      awready = 1'b0;
      chk("t2_awvalid_drop", awvalid, 1'b0);
      chk("t2_bready", bready, 1'b1);
      bvalid = 1'b1; bresp = 2'b01;
      tick();
      bvalid = 1'b0;
      chk("t2_rsp_valid", rsp_valid, 1'b1);
      chk("t2_rsp_resp", rsp_resp, 2'b01);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("t2_single_rsp", rsp_valid, 1'b0);
      chk("t2_no_bready", bready, 1'b0);
      chk("t2_idle_busy", busy, 1'b0);

      // 3: queue fills while the first command stalls on awready
      push_cmd(1'b1, 10'h010, 32'hA000_0000, 4'hF);
      push_cmd(1'b0, 10'h014, 32'h0, 4'h0);
      push_cmd(1'b1, 10'h018, 32'hA000_0002, 4'hC);
      push_cmd(1'b0, 10'h01C, 32'h0, 4'h0);
      push_cmd(1'b1, 10'h020, 32'hA000_0004, 4'h1);
      cmd_write = 1'b0; cmd_addr = 10'h024; cmd_valid = 1'b1;
      chk("t3_full_ready", cmd_ready, 1'b0);
      tick();
      chk("t3_full_ready_hold", cmd_ready, 1'b0);
      chk("t3_stall_awaddr", awaddr, 10'h010);
      cmd_valid = 1'b0;
      do_txn("t3_c0", 1'b1, 10'h010, 32'hA000_0000, 4'hF, 32'h0, 2'b00);
      chk("t3_ready_after_pop", cmd_ready, 1'b1);
      push_cmd(1'b0, 10'h024, 32'h0, 4'h0);
      do_txn("t3_c1", 1'b0, 10'h014, 32'h0, 4'h0, 32'hA5A5_0001, 2'b00);
      do_txn("t3_c2", 1'b1, 10'h018, 32'hA000_0002, 4'hC, 32'h0, 2'b11);
      do_txn("t3_c3", 1'b0, 10'h01C, 32'h0, 4'h0, 32'hA5A5_0003, 2'b01);
      do_txn("t3_c4", 1'b1, 10'h020, 32'hA000_0004, 4'h1, 32'h0, 2'b00);
      do_txn("t3_c5", 1'b0, 10'h024, 32'h0, 4'h0, 32'hA5A5_0005, 2'b00);
      chk("t3_busy_low", busy, 1'b0);

      // 4: read with SLVERR passes data and response through
      push_cmd(1'b0, 10'h004, 32'h0, 4'h0);
      do_txn("t4", 1'b0, 10'h004, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10);

      // 5: watchdog with bvalid withheld for 20 cycles
      push_cmd(1'b1, 10'h00C, 32'h0000_00FF, 4'hF);
      tick();
      awready = 1'b1; wready = 1'b1;
      tick();
      awready = 1'b0; wready = 1'b0;
      chk("t5_bready", bready, 1'b1);
      chk("t5_wait1_err", timeout_err, 1'b0);
      for (int i = 2; i <= 16; i++) tick();
      chk("t5_wait16_err", timeout_err, 1'b0);
      timeout_clr = 1'b1;
      tick();
      timeout_clr = 1'b0;
      chk("t5_set_wins", timeout_err, 1'b1);
      chk("t5_still_waiting", bready, 1'b1);
      for (int i = 18; i <= 21; i++) tick();
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      chk("t5_rsp_valid", rsp_valid, 1'b1);
      chk("t5_rsp_write", rsp_write, 1'b1);
      chk("t5_err_sticky", timeout_err, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t5_err_after_rsp", timeout_err, 1'b1);
      timeout_clr = 1'b1;
      tick();
      timeout_clr = 1'b0;
      chk("t5_err_cleared", timeout_err, 1'b0);

      // 6: reset in RD_DATA with another command queued
      push_cmd(1'b0, 10'h008, 32'h0, 4'h0);
      tick();
      chk("t6_arvalid", arvalid, 1'b1);
      arready = 1'b1;
      tick();
      arready = 1'b0;
      chk("t6_rready", rready, 1'b1);
      push_cmd(1'b1, 10'h030, 32'h5555_AAAA, 4'hF);
      chk("t6_busy_pre", busy, 1'b1);
      #2 axi_reset = 1'b1;
      #1;
      chk("t6_rready_rst", rready, 1'b0);
      chk("t6_rsp_valid_rst", rsp_valid, 1'b0);
      chk("t6_busy_rst", busy, 1'b0);
      tick();
      axi_reset = 1'b0;
      tick();
      tick();
      chk("t6_post_busy", busy, 1'b0);
      chk("t6_post_awvalid", awvalid, 1'b0);
      chk("t6_post_arvalid", arvalid, 1'b0);
      chk("t6_post_rsp_valid", rsp_valid, 1'b0);
      chk("t6_post_cmd_ready", cmd_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end
endmodule
